id_ex_stage: RTL and testbench

- Parametrised decode-to-execute stage: integrated register file with write-through bypass, ID/EX pipeline register with valid bit, and load-use hazard detection.
- Sits between the fetch/decode register and the execute stage.
- Control decode and immediate generation stay in external combinational blocks; their outputs enter as a packed control bundle and an immediate.
- Adds stall, flush/bubble insertion, same-cycle writeback bypass and a parametrised register count.

---
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// Decode-to-execute stage: register file with write-first bypass, ID/EX pipeline
// register with valid bit, and load-use hazard detection with bubble insertion.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              MemReadD,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [4:0]        RDW,
  input  logic [XLEN-1:0]   ResultW,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              MemReadE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              StallF,
  output logic              StallD
);

  localparam logic [5:0] NREGS_L = 6'(NREGS);

  logic [4:0] instr_rs1, instr_rs2, instr_rd;
  assign instr_rs1 = InstrD[19:15];
  assign instr_rs2 = InstrD[24:20];
  assign instr_rd  = InstrD[11:7];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

  // x0 has no storage; indices at or above NREGS fall through to zero.
  logic [XLEN-1:0] rf_q [1:NREGS-1];
  logic            rf_we;
  assign rf_we = RegWriteW && (RDW != 5'd0) && ({1'b0, RDW} < NREGS_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      for (int i = 1; i < NREGS; i++)
        if (RDW == 5'(i)) rf_q[i] <= ResultW;
    end
  end

  logic [XLEN-1:0] rd1_d, rd2_d;
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (instr_rs1 == 5'(i)) rd1_d = rf_q[i];
      if (instr_rs2 == 5'(i)) rd2_d = rf_q[i];
    end
    if (rf_we && (RDW == instr_rs1)) rd1_d = ResultW;
    if (rf_we && (RDW == instr_rs2)) rd2_d = ResultW;
  end

  logic              valid_q, memread_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]   rd1_q, rd2_q, imm_q, pc_q, pcp4_q;

  logic load_use, bubble;
  assign load_use = ValidD && valid_q && memread_q && (rd_q != 5'd0) &&
                    ((rd_q == instr_rs1) || (rd_q == instr_rs2));
  assign bubble   = FlushE || load_use;
  assign StallF   = load_use;
  assign StallD   = load_use;

  // A bubble only kills the control side; data fields still follow D.
  logic              valid_d, memread_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [4:0]        rd_d;
  always_comb begin
    valid_d   = ValidD;
    memread_d = MemReadD;
    ctrl_d    = CtrlD;
    rd_d      = instr_rd;
    if (bubble) begin
      valid_d   = 1'b0;
      memread_d = 1'b0;
      ctrl_d    = '0;
      rd_d      = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      memread_q <= 1'b0;
      ctrl_q    <= '0;
      rd_q      <= 5'd0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      pcp4_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      memread_q <= memread_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      rs1_q     <= instr_rs1;
      rs2_q     <= instr_rs2;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= ImmExtD;
      pc_q      <= PCD;
      pcp4_q    <= PCPlus4D;
    end
  end

  assign ValidE   = valid_q;
  assign CtrlE    = ctrl_q;
  assign MemReadE = memread_q;
  assign RdE      = rd_q;
  assign Rs1E     = rs1_q;
  assign Rs2E     = rs2_q;
  assign RD1E     = rd1_q;
  assign RD2E     = rd2_q;
  assign ImmExtE  = imm_q;
  assign PCE      = pc_q;
  assign PCPlus4E = pcp4_q;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// Bench for id_ex_stage: one 32-register and one 16-register instance share the
// same stimulus and are compared against an architectural model of the stage.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CW   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]     InstrD = '0;
  logic            ValidD = 1'b0;
  logic [XLEN-1:0] PCD = '0, PCPlus4D = '0, ImmExtD = '0, ResultW = '0;
  logic [CW-1:0]   CtrlD = '0;
  logic            MemReadD = 1'b0, FlushE = 1'b0, RegWriteW = 1'b0;
  logic [4:0]      RDW = '0;

  logic            valid_w [2], mr_w [2], stall_f [2], stall_d [2];
  logic [CW-1:0]   ctrl_w [2];
  logic [XLEN-1:0] rd1_w [2], rd2_w [2], imm_w [2], pc_w [2], pcp4_w [2];
  logic [4:0]      rs1_w [2], rs2_w [2], rd_w [2];

  id_ex_stage #(.XLEN(XLEN), .NREGS(32), .CTRL_W(CW)) dut32 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .CtrlD(CtrlD), .MemReadD(MemReadD), .ImmExtD(ImmExtD),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .ValidE(valid_w[0]), .CtrlE(ctrl_w[0]), .MemReadE(mr_w[0]), .RD1E(rd1_w[0]),
    .RD2E(rd2_w[0]), .ImmExtE(imm_w[0]), .PCE(pc_w[0]), .PCPlus4E(pcp4_w[0]),
    .Rs1E(rs1_w[0]), .Rs2E(rs2_w[0]), .RdE(rd_w[0]),
    .StallF(stall_f[0]), .StallD(stall_d[0]));

  id_ex_stage #(.XLEN(XLEN), .NREGS(16), .CTRL_W(CW)) dut16 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .CtrlD(CtrlD), .MemReadD(MemReadD), .ImmExtD(ImmExtD),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .ValidE(valid_w[1]), .CtrlE(ctrl_w[1]), .MemReadE(mr_w[1]), .RD1E(rd1_w[1]),
    .RD2E(rd2_w[1]), .ImmExtE(imm_w[1]), .PCE(pc_w[1]), .PCPlus4E(pcp4_w[1]),
    .Rs1E(rs1_w[1]), .Rs2E(rs2_w[1]), .RdE(rd_w[1]),
    .StallF(stall_f[1]), .StallD(stall_d[1]));

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic          mr;
    logic [31:0]   rd1, rd2, imm, pc, pcp4;
    logic [4:0]    rs1, rs2, rd;
  } e_t;

  e_t obs [2];
  e_t expd [2];
  always_comb begin
    for (int m = 0; m < 2; m++)
      obs[m] = '{valid_w[m], ctrl_w[m], mr_w[m], rd1_w[m], rd2_w[m], imm_w[m],
                 pc_w[m], pcp4_w[m], rs1_w[m], rs2_w[m], rd_w[m]};
  end

  // Architectural register contents per instance; unimplemented indices stay 0.
  logic [31:0] mrf [2][32];
  int          nregs [2] = '{32, 16};
  int          tests = 0;
  int          failed = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] mread(input int m, input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= nregs[m]) return 32'h0;
    if (RegWriteW && RDW == idx) return ResultW;
    return mrf[m][idx];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      expd[m] = '0;
      for (int r = 0; r < 32; r++) mrf[m][r] = 32'h0;
    end
  endtask

  task automatic check_e(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_valid", tag, m), 32'(obs[m].valid), 32'(expd[m].valid));
      chk($sformatf("%s_m%0d_ctrl", tag, m), 32'(obs[m].ctrl), 32'(expd[m].ctrl));
      chk($sformatf("%s_m%0d_memread", tag, m), 32'(obs[m].mr), 32'(expd[m].mr));
      chk($sformatf("%s_m%0d_rd1", tag, m), obs[m].rd1, expd[m].rd1);
      chk($sformatf("%s_m%0d_rd2", tag, m), obs[m].rd2, expd[m].rd2);
      chk($sformatf("%s_m%0d_imm", tag, m), obs[m].imm, expd[m].imm);
      chk($sformatf("%s_m%0d_pc", tag, m), obs[m].pc, expd[m].pc);
      chk($sformatf("%s_m%0d_pcp4", tag, m), obs[m].pcp4, expd[m].pcp4);
      chk($sformatf("%s_m%0d_rs1", tag, m), 32'(obs[m].rs1), 32'(expd[m].rs1));
      chk($sformatf("%s_m%0d_rs2", tag, m), 32'(obs[m].rs2), 32'(expd[m].rs2));
      chk($sformatf("%s_m%0d_rd", tag, m), 32'(obs[m].rd), 32'(expd[m].rd));
    end
  endtask

  // One clock: check hazard outputs mid-cycle, predict E contents, check after edge.
  task automatic step(input string tag);
    logic lu, bub;
    e_t   nxt [2];
    @(negedge clk);
    lu = ValidD && expd[0].valid && expd[0].mr && expd[0].rd != 5'd0 &&
         (expd[0].rd == InstrD[19:15] || expd[0].rd == InstrD[24:20]);
    bub = FlushE || lu;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_m%0d_stallf", tag, m), 32'(stall_f[m]), 32'(lu));
      chk($sformatf("%s_m%0d_stalld", tag, m), 32'(stall_d[m]), 32'(lu));
      nxt[m].valid = bub ? 1'b0 : ValidD;
      nxt[m].ctrl  = bub ? '0 : CtrlD;
      nxt[m].mr    = bub ? 1'b0 : MemReadD;
      nxt[m].rd    = bub ? 5'd0 : InstrD[11:7];
      nxt[m].rs1   = InstrD[19:15];
      nxt[m].rs2   = InstrD[24:20];
      nxt[m].rd1   = mread(m, InstrD[19:15]);
      nxt[m].rd2   = mread(m, InstrD[24:20]);
      nxt[m].imm   = ImmExtD;
      nxt[m].pc    = PCD;
      nxt[m].pcp4  = PCPlus4D;
      if (RegWriteW && RDW != 5'd0 && int'(RDW) < nregs[m]) mrf[m][RDW] = ResultW;
    end
    @(posedge clk);
    #1;
    expd = nxt;
    check_e(tag);
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic [CW-1:0] ctrl,
                       input logic [31:0] pc);
    ValidD   = v;
    InstrD   = {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
    MemReadD = mr;
    CtrlD    = ctrl;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    ImmExtD  = $urandom;
  endtask

  initial begin
    model_reset();
    #1;
    check_e("reset0");
    @(negedge clk);
    rst = 1'b1;

    // write-through bypass into x5
    set_d(1, 5, 0, 1, 0, 10'h003, 32'h100);
    RegWriteW = 1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
    step("bypass");
    chk("bypass_rd1_m0", obs[0].rd1, 32'hDEADBEEF);
    chk("bypass_rd1_m1", obs[1].rd1, 32'hDEADBEEF);

    // writes to x0 are dropped
    set_d(1, 0, 5, 2, 0, 10'h004, 32'h104);
    RDW = 5'd0; ResultW = 32'hFFFFFFFF;
    step("x0wr");
    RegWriteW = 0;
    set_d(1, 0, 0, 2, 0, 10'h004, 32'h108);
    step("x0rd");
    chk("x0_read", obs[0].rd1, 32'h0);

    // load-use: lw x7 then add using x7 as rs2
    set_d(1, 1, 2, 7, 1, 10'h155, 32'h200);
    step("lw");
    set_d(1, 3, 7, 8, 0, 10'h0AA, 32'h204);
    #1;
    chk("lu_stallf", 32'(stall_f[0]), 32'h1);
    chk("lu_stalld", 32'(stall_d[0]), 32'h1);
    step("lu_bubble");
    chk("lu_bubble_valid", 32'(obs[0].valid), 32'h0);
    chk("lu_bubble_ctrl", 32'(obs[0].ctrl), 32'h0);
    chk("lu_bubble_rd", 32'(obs[0].rd), 32'h0);
    #1;
    chk("lu_release_stalld", 32'(stall_d[0]), 32'h0);
    step("lu_advance");
    chk("lu_adv_valid", 32'(obs[0].valid), 32'h1);
    chk("lu_adv_rd", 32'(obs[0].rd), 32'd8);
    chk("lu_adv_ctrl", 32'(obs[0].ctrl), 32'h0AA);

    // load to x0 and non-load producer: no stall
    set_d(1, 1, 2, 0, 1, 10'h011, 32'h300);
    step("lw_x0");
    set_d(1, 0, 0, 3, 0, 10'h012, 32'h304);
    #1;
    chk("nostall_rd0", 32'(stall_f[0]), 32'h0);
    step("use_x0");
    set_d(1, 1, 2, 7, 0, 10'h013, 32'h308);
    step("alu_x7");
    set_d(1, 7, 7, 4, 0, 10'h014, 32'h30C);
    #1;
    chk("nostall_nomem", 32'(stall_f[0]), 32'h0);
    step("use_x7");

    // flush of a valid D instruction
    FlushE = 1;
    set_d(1, 1, 2, 9, 0, 10'h3FF, 32'h40);
    step("flush");
    chk("flush_valid", 32'(obs[0].valid), 32'h0);
    chk("flush_ctrl", 32'(obs[0].ctrl), 32'h0);
    chk("flush_pc", obs[0].pc, 32'h40);
    FlushE = 0;

    // register count: x20 absent on the 16-register instance, x15 present
    RegWriteW = 1; RDW = 5'd20; ResultW = 32'hCAFE0020;
    set_d(1, 0, 0, 1, 0, 10'h001, 32'h500);
    step("wr20");
    RDW = 5'd15; ResultW = 32'h00001234;
    set_d(1, 20, 0, 1, 0, 10'h001, 32'h504);
    step("rd20");
    chk("n16_rd20", obs[1].rd1, 32'h0);
    chk("n32_rd20", obs[0].rd1, 32'hCAFE0020);
    RegWriteW = 0;
    set_d(1, 15, 20, 1, 0, 10'h001, 32'h508);
    step("rd15");
    chk("n16_rd15", obs[1].rd1, 32'h00001234);
    chk("n16_rd20b", obs[1].rd2, 32'h0);

    // asynchronous reset mid-stream with a valid instruction in E
    set_d(1, 1, 2, 3, 1, 10'h2F0, 32'h600);
    step("pre_rst");
    chk("pre_rst_valid", 32'(obs[0].valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_e("async_rst");
    @(posedge clk);
    #1;
    check_e("rst_held");
    @(negedge clk);
    rst = 1'b1;
    set_d(1, 5, 15, 1, 0, 10'h001, 32'h700);
    step("post_rst");
    chk("post_rst_x5", obs[0].rd1, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r1, r2;
      r1 = 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? expd[0].rd : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        logic [4:0] t;
        t = r1; r1 = r2; r2 = t;
      end
      set_d(1'($urandom_range(0, 6) != 0), r1, r2, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 4) < 2), 10'($urandom), $urandom);
      FlushE    = ($urandom_range(0, 9) == 0);
      RegWriteW = ($urandom_range(0, 4) < 3);
      RDW       = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
      ResultW   = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
